// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer driving one shared full-adder cell
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [CW-1:0] cnt;
  logic carry;
  // busy is high exactly in RUN, so it gates the cell inputs to zero elsewhere
  assign fa_a = busy & a_sh[0];
  assign fa_b = busy & b_sh[0];
  assign fa_c = busy & carry;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= fa_cout;
      sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        sum   <= {fa_sum, sum_sh[WIDTH-1:1]};
        cout  <= fa_cout;
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      done  <= 1'b0;
      busy  <= start;
      state <= start ? RUN : IDLE;
      if (start) begin
        a_sh  <= op_a;
        b_sh  <= op_b;
        carry <= cin;
        cnt   <= '0;
      end
    end
  end
endmodule
